i2c_coeff_master: RTL and testbench

//  Bit-level I2C master (write-only) that loads FIR coefficients into the filter's I2C slave.
//  On start_in it sends START, then address byte {DEV_ADDR,1'b0}, then NBYTES data bytes.
//  The data bytes are pulled from a valid/ready byte source.
//  It checks the slave ACK after every byte, then sends STOP.

---
 rtl/i2c_coeff_master.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_coeff_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_coeff_master.sv
// rtl/i2c_coeff_master.sv - write-only bit-level I2C master that streams coefficient bytes to a slave
module i2c_coeff_master #(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter int         NBYTES   = 8,
    parameter int         CLK_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_in,
    input  logic [7:0] byte_in,
    input  logic       byte_valid_in,
    output logic       byte_ready_out,
    output logic       scl_oe_out,
    output logic       sda_oe_out,
    input  logic       sda_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       nack_out
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        FETCH,
        DATA,
        DATA_ACK,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         qtr_q, qtr_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic               ack_q, ack_d;
    logic               nack_q, nack_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               scl_q, scl_d;
    logic               sda_q, sda_d;

    logic               running;
    logic               tick;

    // The quarter divider only advances while the bus is actively clocking.
    assign running = (state_q != IDLE) && (state_q != FETCH);
    assign tick    = running && (div_q == DIV_W'(CLK_DIV - 1));

    // Next-state sequencing plus registered line drives decoded from the next state.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        ack_d      = ack_q;
        nack_d     = nack_q;
        done_d     = 1'b0;

        if (running) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            qtr_d = qtr_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                // A start arriving alongside the done pulse is dropped.
                if (start_in && !done_q) begin
                    state_d    = START;
                    nack_d     = 1'b0;
                    byte_cnt_d = 8'd0;
                    shift_d    = {DEV_ADDR, 1'b0};
                    bit_d      = 3'd0;
                    qtr_d      = 2'd0;
                    div_d      = '0;
                end
            end
            START: begin
                if (tick && qtr_q == 2'd1) begin
                    state_d = ADDR;
                    qtr_d   = 2'd0;
                end
            end
            ADDR, DATA: begin
                if (tick && qtr_q == 2'd3) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            ADDR_ACK, DATA_ACK: begin
                if (tick && qtr_q == 2'd1) begin
                    ack_d = sda_in;
                end
                if (tick && qtr_q == 2'd3) begin
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else if (byte_cnt_q < 8'(NBYTES)) begin
                        state_d = FETCH;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            FETCH: begin
                if (byte_valid_in && ready_q) begin
                    shift_d    = byte_in;
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    state_d    = DATA;
                end
            end
            STOP: begin
                if (tick && qtr_q == 2'd2) begin
                    state_d = IDLE;
                    qtr_d   = 2'd0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
        scl_d   = 1'b0;
        sda_d   = 1'b0;
        case (state_d)
            START: begin
                sda_d = (qtr_d == 2'd1);
            end
            ADDR, DATA: begin
                scl_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
                sda_d = ~shift_d[7];
            end
            ADDR_ACK, DATA_ACK: begin
                scl_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
            end
            FETCH: begin
                scl_d = 1'b1;
            end
            STOP: begin
                scl_d = (qtr_d == 2'd0);
                sda_d = (qtr_d != 2'd2);
            end
            default: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            byte_cnt_q <= 8'd0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            scl_q      <= 1'b0;
            sda_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
        end
    end

    assign byte_ready_out = ready_q;
    assign scl_oe_out     = scl_q;
    assign sda_oe_out     = sda_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign nack_out       = nack_q;

endmodule

// File: tb/tb_i2c_coeff_master.sv
// tb/tb_i2c_coeff_master.sv - scoreboard bench with I2C bus decoder and ACK/NACK slave model
module tb_i2c_coeff_master;

    localparam logic [6:0] DEV_ADDR = 7'h3A;
    localparam int         NBYTES   = 8;
    localparam int         CLK_DIV  = 4;

    logic       clk;
    logic       rst_n;
    logic       start_in;
    logic [7:0] byte_in;
    logic       byte_valid_in;
    logic       byte_ready_out;
    logic       scl_oe_out;
    logic       sda_oe_out;
    logic       sda_in;
    logic       busy_out;
    logic       done_out;
    logic       nack_out;
    logic       slave_pull;

    assign sda_in = ~(sda_oe_out | slave_pull);

    i2c_coeff_master #(
        .DEV_ADDR(DEV_ADDR),
        .NBYTES  (NBYTES),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_in      (start_in),
        .byte_in       (byte_in),
        .byte_valid_in (byte_valid_in),
        .byte_ready_out(byte_ready_out),
        .scl_oe_out    (scl_oe_out),
        .sda_oe_out    (sda_oe_out),
        .sda_in        (sda_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .nack_out      (nack_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int val;
        int ack;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    int src_idx = 0;
    int hs_count = 0;
    int stall_at = -1;
    int stall_len = 0;
    int stall_done = 0;
    int nack_frame = 99;

    int mon_frame = 0;
    int mon_bitn = 0;
    int bus_starts = 0;
    int done_count = 0;
    int ready_cycles = 0;
    int stall_cycles = 0;
    int stall_bad = 0;

    function automatic void check(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endfunction

    function automatic void fail_event(input string name);
        total_cnt++;
        $display("FAIL %s: actual=occurred required=none", name);
    endfunction

    // Reference model: what the bus and the done pulse should show for one transaction.
    task automatic push_expected(input int nack_at, output int exp_hs, output int exp_nack);
        exp_t e;
        e.is_done = 1'b0;
        e.val     = int'({DEV_ADDR, 1'b0});
        e.ack     = (nack_at == 0) ? 1 : 0;
        exp_q.push_back(e);
        exp_hs   = 0;
        exp_nack = (nack_at == 0) ? 1 : 0;
        if (nack_at != 0) begin
            for (int i = 1; i <= NBYTES; i++) begin
                e.is_done = 1'b0;
                e.val     = int'(src_q[i-1]);
                e.ack     = (nack_at == i) ? 1 : 0;
                exp_q.push_back(e);
                exp_hs = i;
                if (nack_at == i) begin
                    exp_nack = 1;
                    break;
                end
            end
        end
        e.is_done = 1'b1;
        e.val     = 0;
        e.ack     = exp_nack;
        exp_q.push_back(e);
    endtask

    task automatic fill_random();
        src_q.delete();
        for (int i = 0; i < NBYTES; i++) begin
            src_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // Byte source: advances on each completed handshake, optionally withholding one byte.
    initial begin
        bit hs;
        byte_valid_in = 1'b0;
        byte_in       = 8'h00;
        forever begin
            @(negedge clk);
            hs = byte_valid_in && byte_ready_out && rst_n;
            @(posedge clk);
            #1;
            if (hs) begin
                hs_count++;
                src_idx++;
            end
            if (src_idx == stall_at && stall_done < stall_len) begin
                byte_valid_in = 1'b0;
                if (byte_ready_out) stall_done++;
            end else if (src_idx < src_q.size()) begin
                byte_valid_in = 1'b1;
                byte_in       = src_q[src_idx];
            end else begin
                byte_valid_in = 1'b0;
                byte_in       = 8'h00;
            end
        end
    end

    // Bus monitor and slave model: decodes START/frames, drives ACK, scores against exp_q.
    initial begin
        logic       scl_l, sda_l, scl_p, sda_p, sda_oe_p;
        logic [8:0] sh;
        exp_t       e;
        slave_pull = 1'b0;
        scl_p      = 1'b1;
        sda_p      = 1'b1;
        sda_oe_p   = 1'b0;
        sh         = 9'd0;
        forever begin
            @(negedge clk);
            scl_l = ~scl_oe_out;
            sda_l = ~(sda_oe_out | slave_pull);
            if (byte_ready_out) ready_cycles++;
            if (byte_ready_out && !byte_valid_in) begin
                stall_cycles++;
                if (!scl_oe_out || sda_oe_out != sda_oe_p) stall_bad++;
            end
            if (done_out) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    fail_event("done_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", int'(e.is_done), 1);
                    check("done_nack", int'(nack_out), e.ack);
                end
            end
            if (scl_p && scl_l && sda_p && !sda_l) begin
                bus_starts++;
                mon_bitn   = 0;
                mon_frame  = 0;
                slave_pull = 1'b0;
            end else if (!scl_p && scl_l) begin
                sh = {sh[7:0], sda_l};
                mon_bitn++;
                if (mon_bitn == 9) begin
                    if (exp_q.size() == 0) begin
                        fail_event("frame_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_kind", int'(e.is_done), 0);
                        check("frame_byte", int'(sh[8:1]), e.val);
                        check("frame_ack", int'(sh[0]), e.ack);
                    end
                    mon_frame++;
                end
            end else if (scl_p && !scl_l) begin
                if (mon_bitn == 8) begin
                    slave_pull = (mon_frame != nack_frame);
                end else if (mon_bitn == 9) begin
                    slave_pull = 1'b0;
                    mon_bitn   = 0;
                end
            end
            scl_p    = scl_l;
            sda_p    = ~(sda_oe_out | slave_pull);
            sda_oe_p = sda_oe_out;
        end
    end

    task automatic run_txn(input int nack_at, input bit extra);
        int exp_hs, exp_nack, st0, dn0, n;
        bit seen_done, pulsed;
        nack_frame = nack_at;
        push_expected(nack_at, exp_hs, exp_nack);
        hs_count     = 0;
        src_idx      = 0;
        ready_cycles = 0;
        st0          = bus_starts;
        dn0          = done_count;
        @(posedge clk);
        #1 start_in = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                start_in = 1'b0;
                check("busy_after_start", int'(busy_out), 1);
            end
        end while (!scl_oe_out && n < 200);
        check("first_scl_low_latency", n, 1 + 2 * CLK_DIV);
        seen_done = 1'b0;
        pulsed    = 1'b0;
        for (int c = 0; c < 20000 && !seen_done; c++) begin
            @(negedge clk);
            if (done_out) begin
                seen_done = 1'b1;
                if (extra) begin
                    start_in = 1'b1;
                    @(posedge clk);
                    #1 start_in = 1'b0;
                end
            end else if (extra && !pulsed && mon_frame == 2) begin
                pulsed   = 1'b1;
                start_in = 1'b1;
                @(posedge clk);
                #1 start_in = 1'b0;
            end
        end
        if (!seen_done) fail_event("done_timeout");
        repeat (20) @(negedge clk);
        check("busy_idle", int'(busy_out), 0);
        check("nack_held", int'(nack_out), exp_nack);
        check("handshakes", hs_count, exp_hs);
        check("done_pulses", done_count - dn0, 1);
        check("bus_starts", bus_starts - st0, 1);
        check("queue_drained", exp_q.size(), 0);
        if (nack_at == 0) check("ready_never", ready_cycles, 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        start_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl_oe", int'(scl_oe_out), 0);
        check("rst_sda_oe", int'(sda_oe_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_done", int'(done_out), 0);
        check("rst_nack", int'(nack_out), 0);
        check("rst_ready", int'(byte_ready_out), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy_out), 0);

        // 1: fixed bytes 0x01..0x08, all acked
        src_q.delete();
        for (int i = 0; i < NBYTES; i++) src_q.push_back(8'(i + 1));
        run_txn(99, 1'b0);

        // 2: address NACK
        fill_random();
        run_txn(0, 1'b0);

        // 3: NACK on third data byte
        fill_random();
        run_txn(3, 1'b0);

        // 4: source withholds the third byte for 50 cycles
        fill_random();
        stall_at     = 2;
        stall_len    = 50;
        stall_done   = 0;
        stall_cycles = 0;
        stall_bad    = 0;
        run_txn(99, 1'b0);
        check("stall_long_enough", int'(stall_cycles >= 50), 1);
        check("stall_bus_frozen", stall_bad, 0);
        stall_at = -1;

        // 5: reset during the 4th bit of the first data byte
        fill_random();
        nack_frame = 99;
        begin
            exp_t e;
            e.is_done = 1'b0;
            e.val     = int'({DEV_ADDR, 1'b0});
            e.ack     = 0;
            exp_q.push_back(e);
        end
        hs_count = 0;
        src_idx  = 0;
        @(posedge clk);
        #1 start_in = 1'b1;
        @(posedge clk);
        #1 start_in = 1'b0;
        n = 0;
        while (!(mon_frame == 1 && mon_bitn == 4 && !scl_oe_out) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) fail_event("reset_point_timeout");
        #3 rst_n = 1'b0;
        #1;
        check("abort_scl_oe", int'(scl_oe_out), 0);
        check("abort_sda_oe", int'(sda_oe_out), 0);
        check("abort_busy", int'(busy_out), 0);
        check("abort_ready", int'(byte_ready_out), 0);
        check("abort_addr_seen", exp_q.size(), 0);
        check("abort_handshakes", hs_count, 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_abort_done", int'(done_out), 0);
        fill_random();
        run_txn(99, 1'b0);

        // 6: stray starts mid-DATA and on the done cycle
        fill_random();
        run_txn(99, 1'b1);

        // randomized transactions with a random NACK point (9 = none)
        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_txn(int'($urandom_range(0, NBYTES + 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
